// File: rtl/mips_core_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: encodings, FSM states,
// ALU operations, decoded-instruction payload and field helpers.
package mips_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_e;

  typedef enum logic [2:0] {
    CL_RTYPE, CL_ADDI, CL_LW, CL_SW, CL_BEQ, CL_HALT, CL_BAD
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    alu_op_e    alu_op;
    logic [4:0] dst;
  } dec_t;

  function automatic logic [5:0] op_of(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] rs_of(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] rt_of(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [15:0] imm_of(input logic [31:0] ir);
    return ir[15:0];
  endfunction

  // Unknown opcodes and unknown R-type functs both classify as CL_BAD.
  function automatic instr_cls_e classify(input logic [31:0] ir);
    instr_cls_e cls;
    cls = CL_BAD;
    case (op_of(ir))
      OP_RTYPE: begin
        case (funct_of(ir))
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls = CL_RTYPE;
          default:                               cls = CL_BAD;
        endcase
      end
      OP_ADDI: cls = CL_ADDI;
      OP_LW:   cls = CL_LW;
      OP_SW:   cls = CL_SW;
      OP_BEQ:  cls = CL_BEQ;
      OP_HALT: cls = CL_HALT;
      default: cls = CL_BAD;
    endcase
    return cls;
  endfunction

  function automatic alu_op_e funct_alu(input logic [5:0] fn);
    alu_op_e op;
    op = ALU_ADD;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: add/sub/and/or/signed slt, with a zero flag used by beq.
module mips_alu
  import mips_core_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = DATA_W'($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: FSM, register file, instruction/data memories
// and a host port for preload and inspection while idle.
module mips_multicycle_core
  import mips_core_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned DMEM_DEPTH = 20,
  parameter logic [31:0] DMEM_BASE  = 32'h1000_4000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              host_we,
  input  logic [1:0]        host_sel,
  input  logic [7:0]        host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              halted,
  output logic              fault,
  output logic [7:0]        pc,
  output logic [15:0]       retired
);

  localparam int unsigned IMEM_AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int unsigned DMEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  state_e state, state_n;

  logic [31:0]         imem [IMEM_DEPTH];
  logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
  logic [DATA_W-1:0]   regs [32];

  logic [31:0]         ir;
  dec_t                dec, dec_c;
  logic [DATA_W-1:0]   a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [DMEM_AW-1:0]  dm_idx;

  logic [DATA_W-1:0]   alu_b, alu_y, ea_off, wb_data;
  logic                alu_zero, ea_bad, host_ok;
  logic [7:0]          br_target;

  logic clr, ld_ir, ld_dec, ld_exec, ld_mdr, retire, pc_take, reg_we, dmem_we;

  // Decode of the latched instruction word.
  always_comb begin
    dec_c.cls    = classify(ir);
    dec_c.alu_op = ALU_ADD;
    dec_c.dst    = rt_of(ir);
    if (dec_c.cls == CL_RTYPE) begin
      dec_c.alu_op = funct_alu(funct_of(ir));
      dec_c.dst    = rd_of(ir);
    end else if (dec_c.cls == CL_BEQ) begin
      dec_c.alu_op = ALU_SUB;
    end
  end

  assign alu_b = (dec.cls == CL_RTYPE || dec.cls == CL_BEQ) ? b_reg : imm_reg;

  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (dec.alu_op),
    .a    (a_reg),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Below-base addresses wrap to a huge offset and fail the range check.
  assign ea_off    = alu_y - DATA_W'(DMEM_BASE);
  assign ea_bad    = (ea_off[1:0] != 2'b00) || (ea_off >= DATA_W'(DMEM_DEPTH * 4));
  assign br_target = pc + 8'd1 + imm_reg[7:0];
  assign wb_data   = (dec.cls == CL_LW) ? mdr : alu_out;
  assign host_ok   = host_we && !busy;

  // State register plus registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_n;
      busy   <= !(state_n inside {S_IDLE, S_HALT, S_FAULT});
      halted <= (state_n == S_HALT);
      fault  <= (state_n == S_FAULT);
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_n = state;
    clr     = 1'b0;
    ld_ir   = 1'b0;
    ld_dec  = 1'b0;
    ld_exec = 1'b0;
    ld_mdr  = 1'b0;
    retire  = 1'b0;
    pc_take = 1'b0;
    reg_we  = 1'b0;
    dmem_we = 1'b0;
    case (state)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          state_n = S_FETCH;
          clr     = 1'b1;
        end
      end
      S_FETCH: begin
        if (32'(pc) >= IMEM_DEPTH) begin
          state_n = S_HALT;
        end else begin
          ld_ir   = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        ld_dec = 1'b1;
        case (dec_c.cls)
          CL_HALT: state_n = S_HALT;
          CL_BAD:  state_n = S_FAULT;
          default: state_n = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (dec.cls)
          CL_BEQ: begin
            retire  = 1'b1;
            pc_take = alu_zero;
            state_n = S_FETCH;
          end
          CL_LW, CL_SW: begin
            if (ea_bad) begin
              state_n = S_FAULT;
            end else begin
              ld_exec = 1'b1;
              state_n = S_MEM;
            end
          end
          default: begin
            ld_exec = 1'b1;
            state_n = S_WB;
          end
        endcase
      end
      S_MEM: begin
        if (dec.cls == CL_SW) begin
          dmem_we = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end else begin
          ld_mdr  = 1'b1;
          state_n = S_WB;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath registers, pc and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      retired <= '0;
      ir      <= '0;
      dec     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
      dm_idx  <= '0;
    end else begin
      if (clr) begin
        pc      <= '0;
        retired <= '0;
      end
      if (ld_ir) ir <= imem[IMEM_AW'(pc)];
      if (ld_dec) begin
        dec     <= dec_c;
        a_reg   <= regs[rs_of(ir)];
        b_reg   <= regs[rt_of(ir)];
        imm_reg <= DATA_W'($signed(imm_of(ir)));
      end
      if (ld_exec) begin
        alu_out <= alu_y;
        dm_idx  <= ea_off[DMEM_AW+1:2];
      end
      if (ld_mdr) mdr <= dmem[dm_idx];
      if (retire) begin
        retired <= retired + 16'd1;
        pc      <= pc_take ? br_target : pc + 8'd1;
      end
    end
  end

  // Register file: host writes only while idle; r0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (host_ok && host_sel == 2'd2 && host_addr < 8'd32) begin
      if (host_addr[4:0] != 5'd0) regs[host_addr[4:0]] <= host_wdata;
    end else if (reg_we && dec.dst != 5'd0) begin
      regs[dec.dst] <= wb_data;
    end
  end

  // Memories are not cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst && host_ok && host_sel == 2'd0 && 32'(host_addr) < IMEM_DEPTH)
      imem[IMEM_AW'(host_addr)] <= 32'(host_wdata);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (host_ok && host_sel == 2'd1 && 32'(host_addr) < DMEM_DEPTH)
        dmem[DMEM_AW'(host_addr)] <= host_wdata;
      else if (dmem_we)
        dmem[dm_idx] <= b_reg;
    end
  end

  // Host read port.
  always_comb begin
    host_rdata = '0;
    case (host_sel)
      2'd0: if (32'(host_addr) < IMEM_DEPTH) host_rdata = DATA_W'(imem[IMEM_AW'(host_addr)]);
      2'd1: if (32'(host_addr) < DMEM_DEPTH) host_rdata = dmem[DMEM_AW'(host_addr)];
      2'd2: if (host_addr < 8'd32)           host_rdata = regs[host_addr[4:0]];
      default: host_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: table of single-instruction programs
// plus hand-written multi-cycle sequences (timing, memory, loop, faults, reset).
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        rst, start, host_we;
  logic [1:0]  host_sel;
  logic [7:0]  host_addr;
  logic [31:0] host_wdata, host_rdata;
  logic        busy, halted, fault;
  logic [7:0]  pc;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  always #5 clk = ~clk;

  mips_multicycle_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .host_we    (host_we),
    .host_sel   (host_sel),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .pc         (pc),
    .retired    (retired)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] r8;
    logic [31:0] r9;
    logic [4:0]  dst;
    logic [31:0] exp;
    logic [7:0]  cyc;
  } vec_t;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] r8, input logic [31:0] r9,
                               input int dst, input logic [31:0] exp, input int cyc);
    vec_t v;
    v.instr = instr; v.r8 = r8; v.r9 = r9; v.dst = 5'(dst); v.exp = exp; v.cyc = 8'(cyc);
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] sel, input int addr, input logic [31:0] data);
    @(negedge clk);
    host_sel = sel; host_addr = 8'(addr); host_wdata = data; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] sel, input int addr, output logic [31:0] data);
    host_sel = sel; host_addr = 8'(addr);
    #1;
    data = host_rdata;
  endtask

  task automatic chk_mem(input string nm, input logic [1:0] sel, input int addr, input logic [31:0] exp);
    logic [31:0] v;
    rd(sel, addr, v);
    check(nm, v, exp);
  endtask

  task automatic go();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge; expiry is a failed check.
  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 1000) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 1000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: busy still 1 after %0d cycles, expected idle", cyc);
    end
  endtask

  vec_t vecs[10];
  int   cyc;

  initial begin
    rst = 1'b1; start = 1'b0; host_we = 1'b0; host_sel = 2'd0; host_addr = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset busy", 32'(busy), 32'd0);
    check("reset halted", 32'(halted), 32'd0);
    check("reset fault", 32'(fault), 32'd0);
    check("reset pc", 32'(pc), 32'd0);
    check("reset retired", 32'(retired), 32'd0);

    // add $9,$8,$8 ; halt with cycle-exact observation
    host_wr(2'd2, 8, 32'd4);
    host_wr(2'd0, 0, rtype(8, 8, 9, 6'h20));
    host_wr(2'd0, 1, HALT_I);
    go();
    repeat (3) @(negedge clk);
    chk_mem("t1 r9 before wb", 2'd2, 9, 32'd0);
    check("t1 busy in wb", 32'(busy), 32'd1);
    @(negedge clk);
    chk_mem("t1 r9 after wb", 2'd2, 9, 32'd8);
    check("t1 retired", 32'(retired), 32'd1);
    check("t1 pc", 32'(pc), 32'd1);
    @(negedge clk);
    check("t1 halted early", 32'(halted), 32'd0);
    @(negedge clk);
    check("t1 halted", 32'(halted), 32'd1);
    check("t1 busy off", 32'(busy), 32'd0);
    check("t1 pc at halt", 32'(pc), 32'd1);
    check("t1 retired final", 32'(retired), 32'd1);

    // Single-instruction programs followed by halt at index 1.
    vecs[0] = mkv(rtype(8, 8, 9, 6'h20),  32'd4, 32'd14, 9, 32'd8, 6);
    vecs[1] = mkv(rtype(8, 9, 10, 6'h22), 32'd4, 32'd14, 10, 32'hFFFF_FFF6, 6);
    vecs[2] = mkv(rtype(9, 8, 12, 6'h2a), 32'd4, 32'hFFFF_FFF6, 12, 32'd1, 6);
    vecs[3] = mkv(rtype(8, 9, 12, 6'h2a), 32'd4, 32'hFFFF_FFF6, 12, 32'd0, 6);
    vecs[4] = mkv(rtype(8, 9, 13, 6'h24), 32'd4, 32'd14, 13, 32'd4, 6);
    vecs[5] = mkv(rtype(8, 9, 14, 6'h25), 32'd4, 32'd14, 14, 32'd14, 6);
    vecs[6] = mkv(itype(6'h08, 8, 8, 16'hFFFF), 32'd4, 32'd14, 8, 32'd3, 6);
    vecs[7] = mkv(itype(6'h08, 0, 0, 16'd5), 32'd4, 32'd14, 0, 32'd0, 6);
    vecs[8] = mkv(rtype(8, 9, 9, 6'h20),  32'h7FFF_FFFF, 32'd1, 9, 32'h8000_0000, 6);
    vecs[9] = mkv(rtype(9, 8, 15, 6'h22), 32'd1, 32'd0, 15, 32'hFFFF_FFFF, 6);

    for (int i = 0; i < 10; i++) begin
      host_wr(2'd2, 8, vecs[i].r8);
      host_wr(2'd2, 9, vecs[i].r9);
      host_wr(2'd0, 0, vecs[i].instr);
      host_wr(2'd0, 1, HALT_I);
      go();
      wait_idle(cyc);
      check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d halted", i), 32'(halted), 32'd1);
      check($sformatf("vec%0d retired", i), 32'(retired), 32'd1);
      chk_mem($sformatf("vec%0d result", i), 2'd2, int'(vecs[i].dst), vecs[i].exp);
    end

    // lw / sw
    host_wr(2'd2, 16, 32'h1000_4004);
    host_wr(2'd2, 8, 32'd4);
    host_wr(2'd1, 1, 32'd11);
    host_wr(2'd1, 2, 32'd98);
    host_wr(2'd0, 0, itype(6'h23, 16, 11, 16'd4));
    go();
    wait_idle(cyc);
    check("lw cycles", 32'(cyc), 32'd7);
    chk_mem("lw r11", 2'd2, 11, 32'd98);
    check("lw pc", 32'(pc), 32'd1);
    host_wr(2'd0, 0, itype(6'h2b, 16, 8, 16'd8));
    go();
    wait_idle(cyc);
    check("sw cycles", 32'(cyc), 32'd6);
    chk_mem("sw dmem3", 2'd1, 3, 32'd4);
    chk_mem("sw r11 kept", 2'd2, 11, 32'd98);
    chk_mem("sw r8 kept", 2'd2, 8, 32'd4);

    // Countdown loop with taken/not-taken beq; host write attempted while busy.
    host_wr(2'd0, 0, itype(6'h08, 0, 8, 16'd3));
    host_wr(2'd0, 1, itype(6'h08, 8, 8, 16'hFFFF));
    host_wr(2'd0, 2, itype(6'h04, 8, 0, 16'd1));
    host_wr(2'd0, 3, itype(6'h04, 0, 0, 16'hFFFD));
    host_wr(2'd0, 4, HALT_I);
    go();
    @(negedge clk);
    host_sel = 2'd2; host_addr = 8'd20; host_wdata = 32'hDEAD; host_we = 1'b1;
    @(negedge clk);
    host_we = 1'b0;
    wait_idle(cyc);
    check("loop cycles", 32'(cyc + 2), 32'd33);
    chk_mem("loop r8", 2'd2, 8, 32'd0);
    check("loop halted", 32'(halted), 32'd1);
    check("loop retired", 32'(retired), 32'd9);
    check("loop pc", 32'(pc), 32'd4);
    chk_mem("busy host write ignored", 2'd2, 20, 32'd0);

    // Faults: misaligned lw, index past end, address below base.
    host_wr(2'd0, 1, HALT_I);
    host_wr(2'd2, 16, 32'h1000_4002);
    host_wr(2'd0, 0, itype(6'h23, 16, 11, 16'd0));
    go();
    wait_idle(cyc);
    check("misalign cycles", 32'(cyc), 32'd3);
    check("misalign fault", 32'(fault), 32'd1);
    check("misalign halted", 32'(halted), 32'd0);
    check("misalign pc", 32'(pc), 32'd0);
    check("misalign retired", 32'(retired), 32'd0);
    chk_mem("misalign r11 kept", 2'd2, 11, 32'd98);

    host_wr(2'd2, 5, 32'h1000_4000);
    host_wr(2'd2, 1, 32'h55);
    host_wr(2'd1, 19, 32'h77);
    host_wr(2'd0, 0, itype(6'h2b, 5, 1, 16'd80));
    go();
    wait_idle(cyc);
    check("sw idx20 fault", 32'(fault), 32'd1);
    chk_mem("sw idx20 dmem19 kept", 2'd1, 19, 32'h77);
    chk_mem("dmem20 reads 0", 2'd1, 20, 32'd0);

    host_wr(2'd0, 0, itype(6'h23, 5, 11, 16'hFFFC));
    go();
    wait_idle(cyc);
    check("below base fault", 32'(fault), 32'd1);
    chk_mem("below base r11 kept", 2'd2, 11, 32'd98);

    host_wr(2'd0, 0, itype(6'h2b, 5, 1, 16'd76));
    go();
    wait_idle(cyc);
    check("sw idx19 fault cleared", 32'(fault), 32'd0);
    check("sw idx19 halted", 32'(halted), 32'd1);
    chk_mem("sw idx19 dmem19", 2'd1, 19, 32'h55);

    host_wr(2'd0, 0, 32'h0C00_0000);
    go();
    wait_idle(cyc);
    check("bad op cycles", 32'(cyc), 32'd2);
    check("bad op fault", 32'(fault), 32'd1);

    host_wr(2'd0, 0, rtype(8, 8, 9, 6'h21));
    go();
    wait_idle(cyc);
    check("bad funct fault", 32'(fault), 32'd1);

    // Branch beyond imem halts without a fault.
    host_wr(2'd0, 0, itype(6'h08, 0, 4, 16'd1));
    host_wr(2'd0, 1, itype(6'h04, 0, 0, 16'd14));
    go();
    wait_idle(cyc);
    check("pc oor cycles", 32'(cyc), 32'd8);
    check("pc oor halted", 32'(halted), 32'd1);
    check("pc oor fault", 32'(fault), 32'd0);
    check("pc oor pc", 32'(pc), 32'd16);
    check("pc oor retired", 32'(retired), 32'd2);

    // host write and start in the same cycle: first fetch sees new word.
    host_wr(2'd0, 1, HALT_I);
    @(negedge clk);
    host_sel = 2'd0; host_addr = 8'd0; host_wdata = itype(6'h08, 0, 3, 16'd7);
    host_we = 1'b1; start = 1'b1;
    @(negedge clk);
    host_we = 1'b0; start = 1'b0;
    wait_idle(cyc);
    check("same-cycle cycles", 32'(cyc), 32'd6);
    chk_mem("same-cycle r3", 2'd2, 3, 32'd7);
    chk_mem("same-cycle r4 untouched", 2'd2, 4, 32'd1);

    // Reset while an add is in EXEC.
    host_wr(2'd0, 0, rtype(8, 8, 9, 6'h20));
    host_wr(2'd2, 8, 32'd4);
    host_wr(2'd2, 9, 32'd0);
    go();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst pc", 32'(pc), 32'd0);
    check("rst retired", 32'(retired), 32'd0);
    chk_mem("rst r9", 2'd2, 9, 32'd0);
    repeat (3) @(negedge clk);
    check("rst stays idle", 32'(busy), 32'd0);
    chk_mem("rst r9 later", 2'd2, 9, 32'd0);
    chk_mem("rst imem kept", 2'd0, 0, rtype(8, 8, 9, 6'h20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
